// File: rtl/msx_mouse_reader.sv
// MSX mouse reader: toggles strobe four times, samples one nibble SETTLE cycles after each
// toggle and publishes dx/dy/buttons with a one-cycle valid pulse. Read length is fixed at 4*SETTLE+2 cycles.
module msx_mouse_reader #(
    parameter int unsigned SETTLE = 512
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] joy_in,
    output logic       strobe,
    output logic       busy,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] buttons,
    output logic       valid,
    output logic       no_device
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0] RELOAD = 16'(SETTLE - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  idx_q;
    logic [15:0] nib_q;
    logic [5:0]  sync1_q;
    logic [5:0]  sync2_q;
    logic        strobe_q;
    logic        busy_q;
    logic        valid_q;
    logic [7:0]  dx_q;
    logic [7:0]  dy_q;
    logic [1:0]  buttons_q;
    logic        no_device_q;
    logic [15:0] nib_d;

    // Slot the synchronized nibble into place; index 0 is the most significant nibble of dx.
    always_comb begin
        nib_d = nib_q;
        case (idx_q)
            2'd0:    nib_d[15:12] = sync2_q[3:0];
            2'd1:    nib_d[11:8]  = sync2_q[3:0];
            2'd2:    nib_d[7:4]   = sync2_q[3:0];
            default: nib_d[3:0]   = sync2_q[3:0];
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 2'd0;
            nib_q       <= 16'd0;
            sync1_q     <= 6'h3F;
            sync2_q     <= 6'h3F;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            dx_q        <= 8'd0;
            dy_q        <= 8'd0;
            buttons_q   <= 2'd0;
            no_device_q <= 1'b0;
        end else begin
            sync1_q <= joy_in;
            sync2_q <= sync1_q;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        strobe_q <= ~strobe_q;
                        cnt_q    <= RELOAD;
                        idx_q    <= 2'd0;
                        busy_q   <= 1'b1;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        nib_q <= nib_d;
                        if (idx_q == 2'd3) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q    <= idx_q + 2'd1;
                            strobe_q <= ~strobe_q;
                            cnt_q    <= RELOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DONE: begin
                    dx_q        <= nib_q[15:8];
                    dy_q        <= nib_q[7:0];
                    no_device_q <= (nib_q == 16'hFFFF);
                    buttons_q   <= ~sync2_q[5:4];
                    valid_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign strobe    = strobe_q;
    assign busy      = busy_q;
    assign dx        = dx_q;
    assign dy        = dy_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign no_device = no_device_q;

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed bench for msx_mouse_reader with a strobe-driven mouse model (SETTLE=8).
module tb_msx_mouse_reader;

    localparam int S = 8;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [5:0] joy_in;
    logic       strobe, busy, valid, no_device;
    logic [7:0] dx, dy;
    logic [1:0] buttons;

    msx_mouse_reader #(.SETTLE(S)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (start),
        .joy_in    (joy_in),
        .strobe    (strobe),
        .busy      (busy),
        .dx        (dx),
        .dy        (dy),
        .buttons   (buttons),
        .valid     (valid),
        .no_device (no_device)
    );

    always #5 clk_sys = ~clk_sys;

    logic       joy_sel = 1'b0;
    logic [5:0] man_joy = 6'h3F;
    logic [5:0] model_joy;
    assign joy_in = joy_sel ? model_joy : man_joy;

    // Mouse model: each strobe toggle presents the next nibble of the loaded sequence.
    logic [3:0] model_nib [16];
    logic [1:0] model_btn = 2'b11;
    logic       model_rst = 1'b1;
    int         model_tog;
    logic       model_ps;

    initial begin
        model_joy = 6'h3F;
        model_tog = 0;
        model_ps  = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (model_rst) begin
                model_tog = 0;
                model_ps  = strobe;
            end else if (strobe !== model_ps) begin
                model_ps  = strobe;
                model_joy = {model_btn, model_nib[model_tog[3:0]]};
                model_tog++;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int         n_tog, n_val;
    int         tog_at [16];
    int         val_at [4];
    logic [7:0] v_dx [4];
    logic [7:0] v_dy [4];
    logic [1:0] v_btn [4];
    logic       v_nd [4];

    task automatic model_load(input logic [63:0] nibs, input logic [1:0] btn);
        for (int j = 0; j < 16; j++) model_nib[j] = nibs[63-4*j -: 4];
        model_btn = btn;
        joy_sel   = 1'b1;
        model_rst = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        model_rst = 1'b0;
    endtask

    // Caller raises start just before; iteration i is sampled after edge k+i.
    task automatic observe(input int ncyc, input int hold_until, input bit repulse,
                           input int rst_at, input bit skew);
        logic ps;
        ps    = strobe;
        n_tog = 0;
        n_val = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_sys);
            if (strobe !== ps) begin
                if (n_tog < 16) tog_at[n_tog] = i;
                n_tog++;
                ps = strobe;
            end
            if (valid === 1'b1) begin
                if (n_val < 4) begin
                    val_at[n_val] = i;
                    v_dx[n_val]   = dx;
                    v_dy[n_val]   = dy;
                    v_btn[n_val]  = buttons;
                    v_nd[n_val]   = no_device;
                end
                n_val++;
            end
            if (i == rst_at) begin
                check("rst_strobe", 32'(strobe), 32'd0);
                check("rst_busy",   32'(busy),   32'd0);
                check("rst_valid",  32'(valid),  32'd0);
                check("rst_dx",     32'(dx),     32'd0);
                check("rst_dy",     32'(dy),     32'd0);
                reset     = 1'b0;
                model_rst = 1'b0;
            end
            if (i == rst_at - 1) begin
                reset     = 1'b1;
                model_rst = 1'b1;
            end
            if (skew && i == 7)  man_joy[3:0] = 4'h2;
            if (skew && i == 21) man_joy[3:0] = 4'h3;
            start = (i + 1 < hold_until) || (repulse && (i == 4 || i == 19));
        end
    endtask

    initial begin
        // Reset with start asserted: start must be ignored.
        start = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("reset_strobe", 32'(strobe), 32'd0);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_valid",  32'(valid),  32'd0);
        check("reset_outs",   {12'd0, dx, dy, buttons, no_device, 1'b0}, 32'd0);
        reset     = 1'b0;
        start     = 1'b0;
        model_rst = 1'b0;
        @(negedge clk_sys);
        check("post_reset_busy",   32'(busy),   32'd0);
        check("post_reset_strobe", 32'(strobe), 32'd0);

        // Basic read: dx=05, dy=FD, button pins 10.
        model_load(64'h05FD_0000_0000_0000, 2'b10);
        start = 1'b1;
        observe(40, 1, 1'b0, -1, 1'b0);
        check("basic_ntog", 32'(n_tog), 32'd4);
        check("basic_tog_at", {tog_at[0][7:0], tog_at[1][7:0], tog_at[2][7:0], tog_at[3][7:0]},
              {8'd0, 8'd8, 8'd16, 8'd24});
        check("basic_nval",   32'(n_val),    32'd1);
        check("basic_val_at", 32'(val_at[0]), 32'd33);
        check("basic_dx",     32'(v_dx[0]),  32'h05);
        check("basic_dy",     32'(v_dy[0]),  32'hFD);
        check("basic_btn",    32'(v_btn[0]), 32'h1);
        check("basic_nd",     32'(v_nd[0]),  32'd0);

        // Idle joystick: all nibbles F means no device.
        joy_sel = 1'b0;
        man_joy = 6'h3F;
        start   = 1'b1;
        observe(40, 1, 1'b0, -1, 1'b0);
        check("nodev_nval",   32'(n_val),    32'd1);
        check("nodev_dxdy",   {16'd0, v_dx[0], v_dy[0]}, 32'hFFFF);
        check("nodev_btn",    32'(v_btn[0]), 32'd0);
        check("nodev_nd",     32'(v_nd[0]),  32'd1);
        check("nodev_ntog",   32'(n_tog),    32'd4);
        check("nodev_strobe", 32'(strobe),   32'd0);

        // Reset at k+13 aborts the read; the next read completes.
        model_load(64'h1234_0000_0000_0000, 2'b11);
        start = 1'b1;
        observe(40, 1, 1'b0, 13, 1'b0);
        check("abort_nval", 32'(n_val), 32'd0);
        model_load(64'hABCD_0000_0000_0000, 2'b11);
        start = 1'b1;
        observe(40, 1, 1'b0, -1, 1'b0);
        check("after_abort_nval", 32'(n_val), 32'd1);
        check("after_abort_val",  {16'd0, v_dx[0], v_dy[0]}, 32'hABCD);

        // Start held high for three back-to-back reads.
        model_load(64'h1020_F001_0000_0000, 2'b11);
        start = 1'b1;
        observe(110, 80, 1'b0, -1, 1'b0);
        check("b2b_ntog", 32'(n_tog), 32'd12);
        check("b2b_nval", 32'(n_val), 32'd3);
        check("b2b_val_at", {8'd0, val_at[0][7:0], val_at[1][7:0], val_at[2][7:0]},
              {8'd0, 8'd33, 8'd67, 8'd101});
        check("b2b_r0", {16'd0, v_dx[0], v_dy[0]}, 32'h1020);
        check("b2b_r1", {16'd0, v_dx[1], v_dy[1]}, 32'hF001);
        check("b2b_r2", {16'd0, v_dx[2], v_dy[2]}, 32'h0000);

        // Start re-pulsed while busy is ignored.
        model_load(64'h3C5A_0000_0000_0000, 2'b01);
        start = 1'b1;
        observe(60, 1, 1'b1, -1, 1'b0);
        check("repulse_ntog", 32'(n_tog), 32'd4);
        check("repulse_nval", 32'(n_val), 32'd1);
        check("repulse_val",  {16'd0, v_dx[0], v_dy[0]}, 32'h3C5A);
        check("repulse_btn",  32'(v_btn[0]), 32'h2);

        // Synchronizer latency: late change keeps old nibble, early change takes new one.
        joy_sel = 1'b0;
        man_joy = {2'b01, 4'h1};
        start   = 1'b1;
        observe(40, 1, 1'b0, -1, 1'b1);
        check("sync_nval", 32'(n_val),    32'd1);
        check("sync_dx",   32'(v_dx[0]),  32'h12);
        check("sync_dy",   32'(v_dy[0]),  32'h33);
        check("sync_btn",  32'(v_btn[0]), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
